// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with bit-valid qualifier, selectable bit order
// and a valid/ready registered word output with a sticky overrun flag.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | out holds no unaccepted word; out_valid = 0
// FULL  | out holds a completed word awaiting out_ready; out_valid = 1
module sipo_deser #(
    parameter int DW = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          si_valid,
    input  logic          si,
    output logic [DW-1:0] out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] sh, sh_shift, out_nxt;
    logic          sample, last_bit, complete, ovr_nxt;

    assign sample   = si_valid & ~clr;
    assign last_bit = (bit_cnt == CW'(DW - 1));
    assign complete = sample & last_bit;

    // sh_shift is the word including the bit sampled on this edge
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_shift = {sh[DW-2:0], si};
        end else begin : g_lsb
            assign sh_shift = {si, sh[DW-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (sample) begin
            sh      <= sh_shift;
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= EMPTY;
            out     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            out     <= out_nxt;
            overrun <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_nxt   = out;
        ovr_nxt   = overrun;
        case (state)
            EMPTY: begin
                if (complete) begin
                    out_nxt   = sh_shift;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (complete) begin
                    // consume-and-replace on the same edge is not an overrun
                    if (out_ready) out_nxt = sh_shift;
                    else           ovr_nxt = 1'b1;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (clr) ovr_nxt = 1'b0;
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_sipo_deser.sv
// Randomised + directed bench for sipo_deser: three instances (DW4 MSB, DW4 LSB, DW8 MSB)
// share stimulus and are checked every cycle against a bit-list reference model.
module tb_sipo_deser;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic clr = 1'b0;
    logic si_valid = 1'b0;
    logic si = 1'b0;
    logic out_ready = 1'b0;

    logic [3:0] o0, o1;
    logic [7:0] o2;
    logic       v0, v1, v2;
    logic [1:0] bc0, bc1;
    logic [2:0] bc2;
    logic       ov0, ov1, ov2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sipo_deser #(.DW(4), .MSB_FIRST(1'b1)) u_m4 (
        .clk(clk), .rstn(rstn), .clr(clr), .si_valid(si_valid), .si(si),
        .out(o0), .out_valid(v0), .out_ready(out_ready), .bit_cnt(bc0), .overrun(ov0));
    sipo_deser #(.DW(4), .MSB_FIRST(1'b0)) u_l4 (
        .clk(clk), .rstn(rstn), .clr(clr), .si_valid(si_valid), .si(si),
        .out(o1), .out_valid(v1), .out_ready(out_ready), .bit_cnt(bc1), .overrun(ov1));
    sipo_deser #(.DW(8), .MSB_FIRST(1'b1)) u_m8 (
        .clk(clk), .rstn(rstn), .clr(clr), .si_valid(si_valid), .si(si),
        .out(o2), .out_valid(v2), .out_ready(out_ready), .bit_cnt(bc2), .overrun(ov2));

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    // Reference model: bits of the word in arrival order, word built arithmetically.
    int mdw[3]  = '{4, 4, 8};
    bit mmsb[3] = '{1'b1, 1'b0, 1'b1};
    int mcnt[3]  = '{0, 0, 0};
    bit mfull[3] = '{0, 0, 0};
    int mword[3] = '{0, 0, 0};
    bit movr[3]  = '{0, 0, 0};
    bit mbits[3][8];

    always @(posedge clk or negedge rstn) begin
        int  cand;
        bit  done;
        if (!rstn) begin
            for (int d = 0; d < 3; d++) begin
                mcnt[d] = 0; mfull[d] = 0; mword[d] = 0; movr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                done = 1'b0;
                if (clr) begin
                    mcnt[d] = 0;
                    movr[d] = 1'b0;
                end else if (si_valid) begin
                    mbits[d][mcnt[d]] = si;
                    if (mcnt[d] == mdw[d] - 1) begin
                        done = 1'b1;
                        mcnt[d] = 0;
                        cand = 0;
                        for (int i = 0; i < mdw[d]; i++)
                            if (mbits[d][i])
                                cand += mmsb[d] ? (1 << (mdw[d] - 1 - i)) : (1 << i);
                        if (!mfull[d] || out_ready) begin
                            mword[d] = cand;
                            mfull[d] = 1'b1;
                        end else begin
                            movr[d] = 1'b1;
                        end
                    end else begin
                        mcnt[d]++;
                    end
                end
                if (!done && mfull[d] && out_ready) mfull[d] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        int a_out[3], a_v[3], a_bc[3], a_ov[3];
        #1;
        a_out = '{int'(o0), int'(o1), int'(o2)};
        a_v   = '{int'(v0), int'(v1), int'(v2)};
        a_bc  = '{int'(bc0), int'(bc1), int'(bc2)};
        a_ov  = '{int'(ov0), int'(ov1), int'(ov2)};
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("model_out[%0d]", d), a_out[d], mword[d]);
            chk($sformatf("model_valid[%0d]", d), a_v[d], int'(mfull[d]));
            chk($sformatf("model_bit_cnt[%0d]", d), a_bc[d], mcnt[d]);
            chk($sformatf("model_overrun[%0d]", d), a_ov[d], int'(movr[d]));
        end
    end

    task automatic step(input bit v, input bit s, input bit r, input bit c);
        @(negedge clk);
        si_valid = v; si = s; out_ready = r; clr = c;
        @(posedge clk);
        #2;
    endtask

    task automatic send4(input bit [3:0] w, input bit r);
        for (int i = 3; i >= 0; i--) step(1'b1, w[i], r, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0; si_valid = 1'b0; clr = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bit [7:0] a5;
        a5 = 8'hA5;
        @(posedge clk); #2;
        chk("reset_out", int'(o0), 0);
        chk("reset_valid", int'(v0), 0);
        chk("reset_bit_cnt", int'(bc2), 0);
        @(negedge clk);
        rstn = 1'b1;

        // MSB-first / LSB-first, back-to-back words
        send4(4'b1010, 1'b1);
        chk("msb_1010", int'(o0), 4'b1010);
        chk("msb_valid", int'(v0), 1);
        chk("lsb_0101", int'(o1), 4'b0101);
        send4(4'b0101, 1'b1);
        chk("msb_0101", int'(o0), 4'b0101);
        chk("dw8_a5_contig", int'(o2), 8'hA5);
        chk("no_overrun", int'(ov0), 0);

        // DW=8 with si_valid gaps
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, a5[i], 1'b1, 1'b0);
            if (i == 7) chk("gap_cnt_after_bit", int'(bc2), 1);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 7) chk("gap_cnt_hold", int'(bc2), 1);
        end
        chk("dw8_a5_gaps", int'(o2), 8'hA5);

        // Backpressure and overrun
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send4(4'b1100, 1'b0);
        chk("bp_first", int'(o0), 4'b1100);
        send4(4'b0011, 1'b0);
        chk("bp_held", int'(o0), 4'b1100);
        chk("bp_overrun", int'(ov0), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_drain", int'(v0), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_overrun", int'(ov0), 0);

        // Accept and completion on the same edge
        send4(4'b1010, 1'b0);
        chk("sim_full", int'(o0), 4'b1010);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("sim_out", int'(o0), 4'b0110);
        chk("sim_valid", int'(v0), 1);
        chk("sim_overrun", int'(ov0), 0);

        // Mid-word reset, then mid-word clear
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        pulse_reset();
        send4(4'b1001, 1'b0);
        chk("rst_mid_word", int'(o0), 4'b1001);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_keeps_valid", int'(v0), 1);
        chk("clr_bit_cnt", int'(bc0), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send4(4'b1001, 1'b0);
        chk("clr_mid_word", int'(o0), 4'b1001);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rstn      = ($urandom_range(0, 999) >= 5);
            si        = 1'($urandom);
            si_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            clr       = ($urandom_range(0, 99) < 3);
        end
        @(negedge clk);
        rstn = 1'b1; si_valid = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserialiser with a bit-valid qualifier, selectable bit order and a valid/ready word output. It collects `DW` qualified serial bits into a word and presents that word on a registered output held until a downstream consumer accepts it. It replaces the fixed-width, free-running SIPO wherever serial links feed word-oriented logic that can stall.

## Interface

**Parameters**

- `DW`, 4: word width in bits; legal range DW ≥ 2.
- `MSB_FIRST`, 1:
  - 1: the first received bit lands in `out[DW-1]`.
  - 0: the first received bit lands in `out[0]`.
- `CW`, $clog2(DW): width of `bit_cnt`. Localparam; not overridable.

**Ports** (one clock; reset is asynchronous and active-low)

- `clk` input 1: clock; all state is updated on the rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `clr` input 1: synchronous clear of the partial word and of `overrun`.
- `si_valid` input 1: qualifies `si`; a bit is sampled only when this is 1.
- `si` input 1: serial data.
- `out` output DW: assembled word; registered.
- `out_valid` output 1: `out` holds a word that has not yet been accepted.
- `out_ready` input 1: consumer accepts `out` on any edge where `out_valid` and `out_ready` are both 1.
- `bit_cnt` output CW: number of bits in the partial word, 0..DW-1.
- `overrun` output 1: sticky flag; a completed word was dropped.

## Operation

**Reset** (`rstn` = 0): takes effect immediately, regardless of clock.

- `out` = 0, `out_valid` = 0, `bit_cnt` = 0, `overrun` = 0, internal shift register = 0.
- A word in progress is discarded.

**Sampling:** on each edge with `si_valid` = 1 and `clr` = 0:

- If `MSB_FIRST` = 1: `sh <= {sh[DW-2:0], si}`.
- If `MSB_FIRST` = 0: `sh <= {si, sh[DW-1:1]}`.
- `bit_cnt` increments.
- When `si_valid` = 0, `sh` and `bit_cnt` hold.

**Word completion:** the edge where `bit_cnt` = DW-1 and a bit is sampled.

- The complete word (`sh` including the new bit) is the candidate.
- `bit_cnt` wraps to 0.

**Output register:** two states, EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).

- EMPTY + completion: `out` <= candidate, go to FULL.
- FULL + `out_ready` = 1, no completion: go to EMPTY. `out` keeps its last value.
- FULL + `out_ready` = 1 + completion on the same edge: the old word is consumed and `out` <= candidate. Stay FULL; no overrun.
- FULL + `out_ready` = 0 + completion: the candidate is dropped, `out` is unchanged, `overrun` <= 1.
- `out_ready` while EMPTY: ignored.

**Clear** (`clr` = 1 on an edge):

- `sh` = 0, `bit_cnt` = 0, `overrun` = 0.
- A bit sampled on the same edge is discarded.
- `out` and `out_valid` are unaffected; a pending accept on the same edge still completes.

**Overrun:** stays set until `clr` or reset.

## Timing

- Throughput: one bit per clock. Back-to-back words complete every DW qualified cycles with no gap.
- Latency: `out`/`out_valid` update on the same edge that samples the DW-th bit, and are visible immediately after it.
- `bit_cnt` reflects bits sampled up to and including the previous edge.
- Stimulus convention for benches: drive `si`, `si_valid`, `out_ready` and `clr` on the falling edge.
- Reset mid-word: the next word starts from bit 0 after `rstn` rises. The first edge with `rstn` = 1 may sample.
- `si_valid` gaps of any length inside a word are legal and do not alter word content.

## Test plan

- **Reset, MSB-first:** reset, then shift 1010 then 0101 with `out_ready` = 1.
  - `out` = 4'b1010 with `out_valid` = 1 after the 4th bit.
  - `out` = 4'b0101 four cycles later.
  - `overrun` = 0 throughout.
- **LSB-first** (`MSB_FIRST` = 0): shift bits 1,0,1,0 → `out` = 4'b0101.
- **Gaps and width** (DW = 8): drive 8'hA5 with `si_valid` low on alternate cycles → `out` = 8'hA5. `bit_cnt` sequence is 0,1,1,2,2,…
- **Backpressure:** hold `out_ready` = 0.
  - Complete 1100, then 0011.
  - `out` stays 4'b1100 and `overrun` = 1.
  - Raise `out_ready`: `out_valid` falls the next edge.
  - `clr` clears `overrun`.
- **Simultaneous accept and completion:** FULL with 1010, `out_ready` = 1 on the edge completing 0110.
  - `out` = 4'b0110, `out_valid` stays 1, `overrun` = 0.
- **Mid-word interruption:**
  - Assert `rstn` = 0 after 2 bits of a word, then send 1001 → `out` = 4'b1001.
  - Repeat using `clr` instead of reset → same result.
  - `out_valid` is unaffected by `clr`.
